// File: rtl/ram_pkg.sv
// Shared sizes, state encoding and window-offset helpers for the pixel window reader.
package ram_pkg;

  localparam int unsigned PictureSize    = 28;
  localparam int unsigned Size1          = 16;
  localparam int unsigned SizeAddressPix = 16;
  localparam int unsigned WinCount       = 9;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StHold,
    StDone
  } state_e;

  // Row offset (k/3) of window index k within the 3x3 window.
  function automatic logic [1:0] k_row(input logic [3:0] k);
    logic [1:0] r;
    r = 2'd0;
    if (k >= 4'd6) begin
      r = 2'd2;
    end else if (k >= 4'd3) begin
      r = 2'd1;
    end
    return r;
  endfunction

  // Column offset (k%3) of window index k within the 3x3 window.
  function automatic logic [1:0] k_col(input logic [3:0] k);
    logic [1:0] c;
    c = 2'd0;
    case (k)
      4'd1, 4'd4, 4'd7: c = 2'd1;
      4'd2, 4'd5, 4'd8: c = 2'd2;
      default:          c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/win_addr_gen.sv
// Maps picture origin, window top-left (row, col) and window index k to a pixel RAM address.
module win_addr_gen
  import ram_pkg::*;
#(
  parameter int unsigned picture_size     = PictureSize,
  parameter int unsigned SIZE_address_pix = SizeAddressPix
) (
  input  logic [SIZE_address_pix-1:0] base,
  input  logic [4:0]                  row,
  input  logic [4:0]                  col,
  input  logic [3:0]                  k,
  output logic [SIZE_address_pix-1:0] addr
);

  localparam int unsigned Aw = SIZE_address_pix;
  localparam logic [Aw-1:0] Pic = Aw'(picture_size);

  logic [Aw-1:0] row_term;
  logic [Aw-1:0] col_term;

  // All terms are kept at address width so the sum wraps modulo 2^Aw.
  always_comb begin
    row_term = Aw'(row) + Aw'(k_row(k));
    col_term = Aw'(col) + Aw'(k_col(k));
    addr     = base + row_term * Pic + col_term;
  end

endmodule

// File: rtl/ram_window_reader.sv
// Scans a square picture in a registered pixel RAM and presents every 3x3 window
// with a valid/ready handshake.
module ram_window_reader
  import ram_pkg::*;
#(
  parameter int unsigned picture_size     = PictureSize,
  parameter int unsigned SIZE_1           = Size1,
  parameter int unsigned SIZE_address_pix = SizeAddressPix
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [SIZE_address_pix-1:0]  base_addr,
  output logic                         re_p,
  output logic [SIZE_address_pix-1:0]  read_addressp,
  input  logic signed [SIZE_1-1:0]     qp,
  output logic [WinCount*SIZE_1-1:0]   window,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4:0]                   win_row,
  output logic [4:0]                   win_col,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned Aw = SIZE_address_pix;
  localparam logic [4:0] LastPos = 5'(picture_size - 3);
  localparam logic [3:0] LastK   = 4'(WinCount - 1);

  state_e        state_q, state_d;
  logic [Aw-1:0] base_q, base_d;
  logic [4:0]    row_q, row_d;
  logic [4:0]    col_q, col_d;
  logic [3:0]    k_q, k_d;
  logic [Aw-1:0] addr_q, addr_next;
  logic          cap_v_q;
  logic [3:0]    cap_k_q;
  logic [WinCount-1:0][SIZE_1-1:0] win_q;

  // Address is computed from next-state values so it registers together with the state.
  win_addr_gen #(
    .picture_size    (picture_size),
    .SIZE_address_pix(SIZE_address_pix)
  ) u_addr_gen (
    .base(base_d),
    .row (row_d),
    .col (col_d),
    .k   (k_d),
    .addr(addr_next)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          base_d  = base_addr;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
        end
      end
      StFetch: begin
        if (k_q == LastK) begin
          state_d = StWait;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      StWait: state_d = StHold;
      StHold: begin
        if (out_ready) begin
          k_d = '0;
          if (col_q == LastPos) begin
            col_d = '0;
            row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
          state_d = (col_q == LastPos && row_q == LastPos) ? StDone : StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      cap_v_q <= 1'b0;
      cap_k_q <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      if (state_d == StFetch) begin
        addr_q <= addr_next;
      end
      // RAM samples the address one edge after it is registered; data is captured one edge later.
      cap_v_q <= (state_q == StFetch);
      cap_k_q <= k_q;
      if (cap_v_q && cap_k_q < 4'(WinCount)) begin
        win_q[cap_k_q] <= qp;
      end
    end
  end

  assign re_p          = (state_q == StFetch);
  assign read_addressp = addr_q;
  assign window        = win_q;
  assign out_valid     = (state_q == StHold);
  assign win_row       = row_q;
  assign win_col       = col_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_ram_window_reader.sv
// Directed self-checking bench for ram_window_reader with a registered RAM holding mem[a]=a.
module tb_ram_window_reader;

  localparam int unsigned W  = 16;
  localparam int unsigned Aw = 16;
  localparam int unsigned Ps = 28;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic [Aw-1:0]     base_addr = '0;
  logic              re_p;
  logic [Aw-1:0]     read_addressp;
  logic signed [W-1:0] qp;
  logic [9*W-1:0]    window;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic [4:0]        win_row;
  logic [4:0]        win_col;

  int n_checks = 0;
  int n_errors = 0;
  int xfers = 0;
  int dones = 0;
  logic [9*W-1:0] last_win = '0;
  logic [4:0]     last_row = '0;
  logic [4:0]     last_col = '0;

  ram_window_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .re_p         (re_p),
    .read_addressp(read_addressp),
    .qp           (qp),
    .window       (window),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .win_row      (win_row),
    .win_col      (win_col),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Registered RAM model, mem[a] = a.
  always @(posedge clk) begin
    if (re_p) qp <= read_addressp;
  end

  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      xfers    <= xfers + 1;
      last_win <= window;
      last_row <= win_row;
      last_col <= win_col;
    end
    if (done) dones <= dones + 1;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9*W-1:0] exp_win(input int base, input int row, input int col);
    logic [9*W-1:0] e;
    logic [Aw-1:0]  a;
    e = '0;
    for (int k = 0; k < 9; k++) begin
      a = Aw'(base + (row + k / 3) * Ps + col + k % 3);
      e[k*W +: W] = a;
    end
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns just after edge 0 (the edge that samples start).
  task automatic do_start(input logic [Aw-1:0] b);
    @(negedge clk);
    base_addr = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_re_p"}, re_p, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, read_addressp, 0);
    check({tag, "_window"}, window, 0);
    check({tag, "_row"}, win_row, 0);
    check({tag, "_col"}, win_col, 0);
  endtask

  initial begin
    int  n;
    int  d0;
    logic prev;
    logic [9*W-1:0] snap;

    // Reset state and no self-start on release
    step(2);
    check_all_zero("rst");
    rst_n = 1'b1;
    step(3);
    check("idle_after_release", busy, 0);

    // First window timing and contents
    out_ready = 1'b1;
    do_start(16'h0000);
    check("t1_re_p_e0", re_p, 1);
    check("t1_addr_e0", read_addressp, 0);
    step(3);
    check("t1_addr_e3", read_addressp, 28);
    step(5);
    check("t1_addr_e8", read_addressp, 58);
    step(1);
    check("t1_wait_re_p", re_p, 0);
    check("t1_valid_e9", out_valid, 0);
    step(1);
    check("t1_valid_e10", out_valid, 1);
    check("t1_window0", window, exp_win(0, 0, 0));
    step(1);
    check("t1_valid_e11", out_valid, 0);
    check("t1_col_e11", win_col, 1);
    step(10);
    check("t1_valid_e21", out_valid, 1);
    check("t1_window1", window, exp_win(0, 0, 1));

    // Full scan, with a start pulse while busy that must be ignored
    step(2);
    base_addr = 16'd100;
    start = 1'b1;
    step(1);
    start = 1'b0;
    base_addr = '0;
    n = 0;
    prev = 1'b0;
    while (!done && n < 8000) begin
      prev = out_valid && out_ready;
      step(1);
      n++;
    end
    check("t2_done_seen", done, 1);
    check("t2_done_after_xfer", prev, 1);
    check("t2_xfers", xfers, 676);
    check("t2_last_row", last_row, 25);
    check("t2_last_col", last_col, 25);
    check("t2_last_w0", last_win[15:0], 725);
    check("t2_last_w2", last_win[47:32], 727);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("t2_done_one_cycle", done, 0);
    check("t2_busy_after", busy, 0);
    step(12);
    check("t2_no_rescan_busy", busy, 0);
    check("t2_no_rescan_re_p", re_p, 0);
    check("t2_one_done", dones, 1);

    // Back-pressure in HOLD
    out_ready = 1'b0;
    do_start(16'h0000);
    step(10);
    check("t3_valid", out_valid, 1);
    snap = window;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t3_stable", window, snap);
      check("t3_re_p_low", re_p, 0);
      check("t3_valid_held", out_valid, 1);
    end
    out_ready = 1'b1;
    step(1);
    check("t3_valid_clr", out_valid, 0);
    check("t3_row", win_row, 0);
    check("t3_col", win_col, 1);
    step(10);
    check("t3_next_valid", out_valid, 1);
    check("t3_next_window", window, exp_win(0, 0, 1));

    // Reset in FETCH of window (3,7)
    n = 0;
    while (!(win_row == 5'd3 && win_col == 5'd7 && re_p) && n < 2000) begin
      step(1);
      n++;
    end
    check("t4_reached_3_7", (win_row == 5'd3 && win_col == 5'd7 && re_p), 1);
    d0 = dones;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t4_async");
    step(2);
    rst_n = 1'b1;
    step(20);
    check("t4_no_done", dones, d0);
    check("t4_idle", busy, 0);
    do_start(16'h0000);
    step(10);
    check("t4_restart_valid", out_valid, 1);
    check("t4_restart_window", window, exp_win(0, 0, 0));
    check("t4_restart_row", win_row, 0);
    check("t4_restart_col", win_col, 0);

    // Address wrap from a high origin
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    do_start(16'hFFF0);
    check("t5_addr0", read_addressp, 16'hFFF0);
    step(3);
    check("t5_addr3", read_addressp, 16'h000C);
    step(7);
    check("t5_window", window, exp_win(32'h0000FFF0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
